// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC register and a hardware return-address stack.
// Optional macro PC_SEQ_TRAP_EN redirects stack faults to TRAP_VECTOR and clears the stack.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_offset,
  input  logic                       jump_reg,
  input  logic [31:0]                reg_target,
  input  logic                       call,
  input  logic                       ret,
  output logic [31:0]                pc,
  output logic [1:0]                 pc_src,
  output logic [31:0]                stack_top,
  output logic [$clog2(DEPTH):0]     stack_depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] SrcStack = 2'b00;
  localparam logic [1:0] SrcReg   = 2'b01;
  localparam logic [1:0] SrcRel   = 2'b10;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [1:0]      src_q, src_d;
  logic [31:0]     top_q, top_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [31:0]     mem_q [DEPTH];

  logic            push_en;
  logic            push_allow;
  logic            fault_evt;
  logic            full;
  logic [AW-1:0]   below_idx;
  logic [31:0]     seq_pc;
  logic [31:0]     rel_pc;

`ifdef PC_SEQ_TRAP_EN
  assign push_allow = (state_q == StRun);
`else
  logic unused_trap;
  assign push_allow  = 1'b1;
  assign unused_trap = ^TRAP_VECTOR;
`endif

  assign full      = (depth_q == DW'(DEPTH));
  // Entry just beneath the top; modulo indexing is safe because it is read only when depth >= 2.
  assign below_idx = depth_q[AW-1:0] - AW'(2);
  assign seq_pc    = pc_q + PC_STEP;
  assign rel_pc    = pc_q + branch_offset;

  always_comb begin
    pc_d      = pc_q;
    src_d     = src_q;
    top_d     = top_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    state_d   = state_q;
    push_en   = 1'b0;
    fault_evt = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (depth_q != '0) begin
          pc_d    = top_q;
          src_d   = SrcStack;
          depth_d = depth_q - DW'(1);
          top_d   = (depth_q > DW'(1)) ? mem_q[below_idx] : '0;
        end else begin
          unf_d     = 1'b1;
          fault_evt = 1'b1;
          pc_d      = seq_pc;
          src_d     = SrcRel;
        end
      end else if (jump_reg) begin
        pc_d  = reg_target;
        src_d = SrcReg;
      end else if (call) begin
        pc_d  = rel_pc;
        src_d = SrcRel;
        if (full) begin
          ovf_d     = 1'b1;
          fault_evt = 1'b1;
        end else if (push_allow) begin
          push_en = 1'b1;
          depth_d = depth_q + DW'(1);
          top_d   = seq_pc;
        end
      end else if (branch_taken) begin
        pc_d  = rel_pc;
        src_d = SrcRel;
      end else begin
        pc_d  = seq_pc;
        src_d = SrcRel;
      end
      if (fault_evt) begin
        state_d = StFault;
      end
`ifdef PC_SEQ_TRAP_EN
      if (fault_evt) begin
        pc_d    = TRAP_VECTOR;
        src_d   = SrcRel;
        depth_d = '0;
        top_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      src_q   <= SrcRel;
      top_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; validity is tracked by depth_q.
  always_ff @(posedge clock) begin
    if (!reset && push_en) begin
      mem_q[depth_q[AW-1:0]] <= seq_pc;
    end
  end

  assign pc          = pc_q;
  assign pc_src      = src_q;
  assign stack_top   = top_q;
  assign stack_depth = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based stack model predicts each cycle's outputs.
module tb_pc_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;

  logic                   clock = 1'b0;
  logic                   reset, stall, branch_taken, jump_reg, call, ret;
  logic [31:0]            branch_offset, reg_target;
  logic [31:0]            pc, stack_top;
  logic [1:0]             pc_src;
  logic [$clog2(DEPTH):0] stack_depth;
  logic                   overflow, underflow;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .PC_STEP     (4),
    .DEPTH       (DEPTH),
    .TRAP_VECTOR (TV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .call         (call),
    .ret          (ret),
    .pc           (pc),
    .pc_src       (pc_src),
    .stack_top    (stack_top),
    .stack_depth  (stack_depth),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  src;
    logic [31:0] top;
    int          depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_stk[$];
  logic [31:0] m_pc;
  logic [1:0]  m_src;
  logic        m_ovf, m_unf;
  int          checks = 0;
  int          errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the stack is a plain queue, each request applied by its rule.
  task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] off,
                      input logic jr, input logic [31:0] tgt, input logic cl, input logic rt);
    exp_t e;
    logic flt;
    @(negedge clock);
    reset = rst; stall = stl; branch_taken = br; branch_offset = off;
    jump_reg = jr; reg_target = tgt; call = cl; ret = rt;
    if (rst) begin
      m_pc = RV; m_src = 2'b10; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!stl) begin
      flt = 1'b0;
      if (rt) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back(); m_src = 2'b00;
        end else begin
          m_unf = 1'b1; flt = 1'b1; m_pc = m_pc + 32'd4; m_src = 2'b10;
        end
      end else if (jr) begin
        m_pc = tgt; m_src = 2'b01;
      end else if (cl) begin
        if (m_stk.size() >= DEPTH) begin
          m_ovf = 1'b1; flt = 1'b1;
`ifdef PC_SEQ_TRAP_EN
        end else if (!(m_ovf || m_unf)) begin
`else
        end else begin
`endif
          m_stk.push_back(m_pc + 32'd4);
        end
        m_pc = m_pc + off; m_src = 2'b10;
      end else if (br) begin
        m_pc = m_pc + off; m_src = 2'b10;
      end else begin
        m_pc = m_pc + 32'd4; m_src = 2'b10;
      end
`ifdef PC_SEQ_TRAP_EN
      if (flt) begin
        m_pc = TV; m_src = 2'b10; m_stk.delete();
      end
`endif
    end
    e.pc = m_pc; e.src = m_src; e.ovf = m_ovf; e.unf = m_unf;
    e.depth = m_stk.size();
    e.top = (m_stk.size() > 0) ? m_stk[$] : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] t);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic do_call(input logic [31:0] off);
    step(1'b0, 1'b0, 1'b0, off, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic do_ret();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents a new registered state; compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pc_src", {30'h0, pc_src}, {30'h0, e.src});
        check("stack_top", stack_top, e.top);
        check("stack_depth", 32'(stack_depth), 32'(e.depth));
        check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
        check("underflow", {31'h0, underflow}, {31'h0, e.unf});
      end
    end
  end

  initial begin
    logic [31:0] off;
    int unsigned r;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    jump_reg = 1'b0; reg_target = '0; call = 1'b0; ret = 1'b0;

    do_reset(); idle(); idle(); idle();
    jump(32'h20); do_call(32'h40); do_ret();
    do_reset();
    for (int i = 0; i < 9; i++) do_call(32'h10);
    idle();
    do_reset(); jump(32'h10); do_ret(); idle(); do_reset();
    jump(32'h40); do_call(32'h100);
    step(1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h80, 1'b0, 1'b1);
    jump(32'h80);
    jump(32'h30);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    do_call(32'h40); do_call(32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    do_call(32'hFFFF_FFF0); do_call(32'h8); do_ret(); do_ret(); do_ret();
    jump(32'hFFFF_FFFC); idle();

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      off = ($urandom_range(0, 9) == 0) ? $urandom() : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 1) == 1) off = -off;
      step(r < 2, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, off,
           $urandom_range(0, 9) == 0, $urandom(), $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 2);
    end
    idle();

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the IF stage. Owns the PC register and a hardware return-address stack, and decides each cycle which of three candidates becomes the next PC: stack top, register operand, or PC-relative target. Drives the 2-bit PC-source select with the same encoding as the IF PC mux: 00 stack, 01 registers, 10 relative/sequential. Sits between the decode/branch unit and the instruction-memory address port.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.
DEPTH, 8, return-stack entries; power of two, 2..64.
TRAP_VECTOR, 32'h0000_0100, target on stack fault; used only with the optional feature.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold PC, stack and flags this cycle.
branch_taken  input  1  load PC + branch_offset.
branch_offset  input  32  signed byte offset, relative to current pc.
jump_reg  input  1  load reg_target.
reg_target  input  32  register-file read data 1.
call  input  1  push pc+PC_STEP, then load PC + branch_offset.
ret  input  1  pop stack top into PC.
pc  output  32  current PC, registered.
pc_src  output  2  source of the current pc, registered: 00 stack, 01 registers, 10 relative/sequential.
stack_top  output  32  current top entry; 0 when empty.
stack_depth  output  log2(DEPTH)+1  number of valid entries.
overflow  output  1  sticky; push attempted while full.
underflow  output  1  sticky; pop attempted while empty.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - pc=RESET_VECTOR, pc_src=10, stack_depth=0, stack_top=0.
  - overflow=0, underflow=0.
  - Stack contents are don't-care.
- stall=1 (and reset=0): all registers hold; every request input is ignored that cycle.
- Priority when not stalled: ret > jump_reg > call > branch_taken > sequential.
- Sequential: pc <= pc+PC_STEP, pc_src <= 10.
- branch_taken: pc <= pc+branch_offset, pc_src <= 10.
- Arithmetic: 32-bit two's-complement add, modulo 2^32; wrap-around past 32'hFFFF_FFFC is not flagged.
- call, not full:
  - Push pc+PC_STEP.
  - stack_depth++.
  - pc <= pc+branch_offset, pc_src <= 10.
- call, full:
  - Push discarded; the stack is unchanged.
  - overflow <= 1.
  - PC updates exactly as for a non-full call.
- jump_reg: pc <= reg_target, pc_src <= 01. Stack is untouched.
- ret, not empty:
  - pc <= stack_top.
  - stack_depth--.
  - pc_src <= 00.
- ret, empty:
  - underflow <= 1.
  - pc <= pc+PC_STEP, pc_src <= 10.
  - stack_depth stays 0.
- Latency: a request sampled at edge N is reflected on pc/pc_src/stack_* after edge N. pc is stable for the whole following cycle.
- stack_top and stack_depth are registered views of the stack. Back-to-back call,call,ret,ret with no idle cycles must work.
- Flags stay set until reset.
- Internal control: FSM with states RUN and FAULT.
  - RUN -> FAULT on the first overflow or underflow.
  - FAULT -> RUN only on reset.
  - In the base build, FAULT affects only the flags.

Optional Feature:
PC_SEQ_TRAP_EN
- Defined:
  - An overflow or underflow event loads pc <= TRAP_VECTOR with pc_src <= 10, instead of the normal update for that request.
  - The stack is cleared (stack_depth=0).
  - While in FAULT, call pushes are suppressed.
- Undefined: behaviour is exactly as in the Behaviour section, and TRAP_VECTOR is unused.

Test Plan:
- Reset then 3 idle cycles -> pc=0,4,8,12; pc_src=10; stack_depth=0; both flags 0.
- pc=0x20, call with offset 0x40 -> pc=0x60, stack_top=0x24, depth=1. Then ret -> pc=0x24, pc_src=00, depth=0.
- DEPTH=8: 9 consecutive calls -> depth=8, overflow=1 after the 9th; stack_top still equals the 8th return address. With PC_SEQ_TRAP_EN: pc=0x100, depth=0.
- ret with empty stack at pc=0x10 -> pc=0x14, underflow=1. Then reset -> underflow=0, pc=0.
- Same cycle ret=1, jump_reg=1 (reg_target=0x80), branch_taken=1 with one stacked entry 0x44 -> pc=0x44, pc_src=00. Then jump_reg alone -> pc=0x80, pc_src=01.
- stall=1 held 3 cycles with call=1 at pc=0x30 -> pc stays 0x30, depth unchanged. Reset asserted during a call burst -> next cycle pc=0, depth=0.
